mmio_gpio: RTL and testbench
============================

Name: mmio_gpio

Overview:
Parametrised memory-mapped GPIO peripheral on the CPU data-memory port. It is the next generation of the fixed LED/7-seg/switch MMIO block. It provides a configurable-width LED register with atomic set/clear aliases and a configurable hex-digit register. It also adds debounced, synchronised switch inputs with per-bit change-detect status (write-1-to-clear), an interrupt enable mask, and a level interrupt output to the core.

Parameters:
LED_WIDTH, 10, number of LED outputs (1..32)
HEX_DIGITS, 6, number of hex digits, 4 bits each (1..8)
SW_WIDTH, 10, number of switch inputs (1..32)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a switch change is accepted (>=1)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  14  word address
byteena  in  4  byte lane enables for writes
clken  in  1  bus cycle strobe
data  in  32  write data
wren  in  1  write request
q  out  32  read data
led  out  LED_WIDTH  LED drive, equal to the LED register
hex  out  4*HEX_DIGITS  digit nibbles, digit 0 in [3:0]; segment decode is external
switch  in  SW_WIDTH  raw asynchronous switch inputs
irq  out  1  level interrupt

Behaviour:
- Bus capture on posedge clock when clken=1: address, byteena, data and wren are registered internally. When clken=0, the registered wren clears to 0 and the other captured fields hold.
- A write takes effect on the clock edge after capture, so registers update 2 edges after the clken edge. If clken is held high with wren=1, a write occurs every cycle.
- Read: q is combinational from the registered address. Data is valid the cycle after the clken edge (1-cycle latency). Unmapped addresses and write-only addresses read 0.
- Register map (word addresses). Unused upper bits read 0 and ignore writes.
  - 0x0 LED, rw. Byte lanes apply per byteena bit.
  - 0x1 HEX, rw, 4*HEX_DIGITS bits. Byte lanes apply.
  - 0x2 SW, ro. Debounced switch state.
  - 0x3 STATUS, rw1c. Per-bit debounced-change flags.
  - 0x4 IRQ_EN, rw, SW_WIDTH bits. Byte lanes apply.
  - 0x5 LED_SET, wo. LED |= data on enabled lanes.
  - 0x6 LED_CLR, wo. LED &= ~data on enabled lanes.
- Switch path:
  - Two-flop synchroniser per bit, then a per-bit debounce counter.
  - If the synchronised bit differs from the debounced bit, the counter increments; otherwise it resets to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced bit toggles and the counter resets.
  - A glitch shorter than DEBOUNCE_CYCLES therefore never changes SW.
- STATUS:
  - A bit sets on the cycle its debounced bit toggles (either direction).
  - Writing 1 clears it; writing 0 has no effect; byteena applies.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- irq = |(STATUS & IRQ_EN), registered. It asserts 1 cycle after the status bit sets.
- Reset (asynchronous, reset_n=0):
  - All captured bus fields, LED, HEX, IRQ_EN, STATUS, synchronisers, debounced state and counters go to 0.
  - Outputs: led=0, hex=0, irq=0, q=0.
  - Reset mid-write discards the write.
  - After reset release, a switch held at 1 is reported as a change after sync plus debounce delay, and sets STATUS.
- Counter width is $clog2(DEBOUNCE_CYCLES+1), minimum 1 bit.

Test Plan:
- Reset, then read 0x0..0x6 -> all read 0; led=0, hex=0, irq=0.
- Write LED=0x3FF with byteena=0001, then read 0x0 -> 0x0FF. Then write LED_SET=0x300 with byteena=0011 -> led=0x3FF. Then write LED_CLR=0x00F -> led=0x3F0.
- DEBOUNCE_CYCLES=4: pulse switch[2]=1 for 3 cycles -> SW stays 0, STATUS=0. Hold it high for 6 cycles -> SW=0x004 exactly 2+4 cycles after the input change, and STATUS=0x004.
- IRQ_EN=0x004 with STATUS[2] set -> irq=1. Write STATUS=0x004 -> irq=0 on the next cycle. Write STATUS=0x004 on the same cycle a new toggle of bit 2 occurs -> STATUS[2] stays 1.
- Write HEX=0x123456 with byteena=1111 -> hex=0x123456, and a read of 0x1 returns 0x00123456 one cycle after clken.
- Assert reset_n=0 asynchronously mid-write with clken=1, wren=1 -> led=0 immediately with no clock edge; the write is not applied after release.

Source files
------------

// File: rtl/mmio_gpio_if.sv
// Data-memory port bundle between the CPU and the GPIO peripheral.
// The CPU drives the request fields and the peripheral returns q.
interface mmio_gpio_if;
  logic [13:0] address;
  logic [3:0]  byteena;
  logic        clken;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q;

  modport master (output address, byteena, clken, data, wren, input q);
  modport slave  (input address, byteena, clken, data, wren, output q);
endinterface

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: LED register with set/clear aliases, hex-digit register,
// debounced switch inputs with write-1-to-clear change status and a masked interrupt.
module mmio_gpio #(
  parameter int unsigned LED_WIDTH       = 10,
  parameter int unsigned HEX_DIGITS      = 6,
  parameter int unsigned SW_WIDTH        = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  mmio_gpio_if.slave              bus,
  output logic [LED_WIDTH-1:0]    led,
  output logic [4*HEX_DIGITS-1:0] hex,
  input  logic [SW_WIDTH-1:0]     switch,
  output logic                    irq
);

  localparam int unsigned HEX_W  = 4 * HEX_DIGITS;
  localparam int unsigned CW_RAW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [31:0] LED_KEEP = 32'((64'd1 << LED_WIDTH) - 64'd1);
  localparam logic [31:0] HEX_KEEP = 32'((64'd1 << HEX_W) - 64'd1);
  localparam logic [31:0] SW_KEEP  = 32'((64'd1 << SW_WIDTH) - 64'd1);

  localparam logic [13:0] A_LED     = 14'h0;
  localparam logic [13:0] A_HEX     = 14'h1;
  localparam logic [13:0] A_SW      = 14'h2;
  localparam logic [13:0] A_STATUS  = 14'h3;
  localparam logic [13:0] A_IRQ_EN  = 14'h4;
  localparam logic [13:0] A_LED_SET = 14'h5;
  localparam logic [13:0] A_LED_CLR = 14'h6;

  logic [13:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_data;
  logic        r_wren;

  // Software-visible registers are held 32 bits wide with unused bits forced to 0.
  logic [31:0] r_led;
  logic [31:0] r_hex;
  logic [31:0] r_irq_en;
  logic [31:0] r_status;
  logic        r_irq;

  logic [SW_WIDTH-1:0] r_sync1;
  logic [SW_WIDTH-1:0] r_sync2;
  logic [SW_WIDTH-1:0] r_sw_db;
  logic [CW-1:0]       r_cnt [SW_WIDTH];

  logic [31:0]         w_mask;
  logic [31:0]         w_wbits;
  logic [31:0]         w_led_nxt;
  logic [31:0]         w_hex_nxt;
  logic [31:0]         w_irq_en_nxt;
  logic [31:0]         w_status_nxt;
  logic [SW_WIDTH-1:0] w_toggle;
  logic [31:0]         w_q;

  always_comb begin
    w_mask  = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};
    w_wbits = r_data & w_mask;

    w_led_nxt = r_led;
    if (r_wren && r_addr == A_LED)          w_led_nxt = (r_led & ~w_mask) | w_wbits;
    else if (r_wren && r_addr == A_LED_SET) w_led_nxt = r_led | w_wbits;
    else if (r_wren && r_addr == A_LED_CLR) w_led_nxt = r_led & ~w_wbits;
    w_led_nxt = w_led_nxt & LED_KEEP;

    w_hex_nxt = r_hex;
    if (r_wren && r_addr == A_HEX) w_hex_nxt = ((r_hex & ~w_mask) | w_wbits) & HEX_KEEP;

    w_irq_en_nxt = r_irq_en;
    if (r_wren && r_addr == A_IRQ_EN) w_irq_en_nxt = ((r_irq_en & ~w_mask) | w_wbits) & SW_KEEP;

    for (int unsigned i = 0; i < SW_WIDTH; i++) begin
      w_toggle[i] = (r_sync2[i] != r_sw_db[i]) && (r_cnt[i] == CMAX);
    end

    // Clear is applied before the new toggles are OR-ed in, so a same-cycle set wins.
    w_status_nxt = r_status;
    if (r_wren && r_addr == A_STATUS) w_status_nxt = r_status & ~w_wbits;
    w_status_nxt = (w_status_nxt | 32'(w_toggle)) & SW_KEEP;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr   <= '0;
      r_be     <= '0;
      r_data   <= '0;
      r_wren   <= 1'b0;
      r_led    <= '0;
      r_hex    <= '0;
      r_irq_en <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sw_db  <= '0;
      for (int unsigned i = 0; i < SW_WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      if (bus.clken) begin
        r_addr <= bus.address;
        r_be   <= bus.byteena;
        r_data <= bus.data;
        r_wren <= bus.wren;
      end else begin
        r_wren <= 1'b0;
      end

      r_led    <= w_led_nxt;
      r_hex    <= w_hex_nxt;
      r_irq_en <= w_irq_en_nxt;
      r_status <= w_status_nxt;
      r_irq    <= |(r_status & r_irq_en);

      r_sync1 <= switch;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < SW_WIDTH; i++) begin
        if (r_sync2[i] != r_sw_db[i]) begin
          if (w_toggle[i]) begin
            r_sw_db[i] <= ~r_sw_db[i];
            r_cnt[i]   <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    unique case (r_addr)
      A_LED:    w_q = r_led;
      A_HEX:    w_q = r_hex;
      A_SW:     w_q = 32'(r_sw_db);
      A_STATUS: w_q = r_status;
      A_IRQ_EN: w_q = r_irq_en;
      default:  w_q = '0;
    endcase
  end

  assign bus.q = w_q;
  assign led   = r_led[LED_WIDTH-1:0];
  assign hex   = r_hex[HEX_W-1:0];
  assign irq   = r_irq;

endmodule

// File: tb/tb_mmio_gpio.sv
// Directed bench for mmio_gpio with a short debounce window.
module tb_mmio_gpio;

  logic        clock;
  logic        reset_n;
  logic [9:0]  led;
  logic [23:0] hex;
  logic [9:0]  sw_in;
  logic        irq;
  int          n_checks;
  int          n_fail;
  logic [31:0] rd;

  mmio_gpio_if bus ();

  mmio_gpio #(
    .LED_WIDTH(10),
    .HEX_DIGITS(6),
    .SW_WIDTH(10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus),
    .led(led),
    .hex(hex),
    .switch(sw_in),
    .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.address = a; bus.byteena = be; bus.data = d; bus.wren = 1'b1; bus.clken = 1'b1;
    cyc();
    bus.clken = 1'b0; bus.wren = 1'b0;
    cyc();
  endtask

  task automatic bus_read(input logic [13:0] a, output logic [31:0] d);
    bus.address = a; bus.wren = 1'b0; bus.clken = 1'b1;
    cyc();
    bus.clken = 1'b0;
    d = bus.q;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    for (int a = 0; a < 7; a++) begin
      bus_read(14'(a), rd);
      n_checks++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_read[%0d]: got %h want 00000000", a, rd); end
    end
    n_checks++;
    if (led !== 10'h0 || hex !== 24'h0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: led=%h hex=%h irq=%b want 0 0 0", led, hex, irq);
    end
  endtask

  task automatic test_led();
    bus_write(14'h0, 4'b0001, 32'h3FF);
    bus_read(14'h0, rd);
    n_checks++;
    if (rd !== 32'h0FF) begin n_fail++; $display("FAIL led_bytelane: got %h want 000000ff", rd); end
    bus_write(14'h5, 4'b0011, 32'h300);
    n_checks++;
    if (led !== 10'h3FF) begin n_fail++; $display("FAIL led_set: got %h want 3ff", led); end
    bus_write(14'h6, 4'b1111, 32'h00F);
    n_checks++;
    if (led !== 10'h3F0) begin n_fail++; $display("FAIL led_clr: got %h want 3f0", led); end
    bus_read(14'h5, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL led_set_readback: got %h want 00000000", rd); end
    bus_read(14'h7, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want 00000000", rd); end
  endtask

  task automatic test_hex();
    bus_write(14'h1, 4'b1111, 32'h00123456);
    n_checks++;
    if (hex !== 24'h123456) begin n_fail++; $display("FAIL hex_out: got %h want 123456", hex); end
    bus_read(14'h1, rd);
    n_checks++;
    if (rd !== 32'h00123456) begin n_fail++; $display("FAIL hex_read: got %h want 00123456", rd); end
    bus_write(14'h1, 4'b0100, 32'hFFFFFFFF);
    bus_read(14'h1, rd);
    n_checks++;
    if (rd !== 32'h00FF3456) begin n_fail++; $display("FAIL hex_lane2: got %h want 00ff3456", rd); end
  endtask

  task automatic test_debounce();
    // Keep the SW register selected so q tracks the debounced state each cycle.
    bus.address = 14'h2; bus.wren = 1'b0; bus.clken = 1'b1;
    cyc();
    sw_in = 10'h004;
    cyc(); cyc(); cyc();
    sw_in = 10'h000;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_checks++;
      if (bus.q !== 32'h0) begin n_fail++; $display("FAIL glitch_sw[%0d]: got %h want 00000000", i, bus.q); end
    end
    sw_in = 10'h004;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      n_checks++;
      if (i < 6 && bus.q !== 32'h0) begin
        n_fail++; $display("FAIL sw_latency[%0d]: got %h want 00000000", i, bus.q);
      end else if (i == 6 && bus.q !== 32'h4) begin
        n_fail++; $display("FAIL sw_latency[%0d]: got %h want 00000004", i, bus.q);
      end
    end
    bus.clken = 1'b0;
    bus_read(14'h3, rd);
    n_checks++;
    if (rd !== 32'h4) begin n_fail++; $display("FAIL status_set: got %h want 00000004", rd); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", irq); end
  endtask

  task automatic test_irq();
    bus_write(14'h4, 4'b1111, 32'hFFFFFFFF);
    bus_read(14'h4, rd);
    n_checks++;
    if (rd !== 32'h3FF) begin n_fail++; $display("FAIL irq_en_width: got %h want 000003ff", rd); end
    bus_write(14'h4, 4'b1111, 32'h004);
    cyc();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_assert: got %b want 1", irq); end
    bus_write(14'h3, 4'b1111, 32'h000);
    bus_read(14'h3, rd);
    n_checks++;
    if (rd !== 32'h4) begin n_fail++; $display("FAIL status_w0: got %h want 00000004", rd); end
    bus_write(14'h3, 4'b1111, 32'h004);
    cyc();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq); end
    bus_read(14'h3, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL status_w1c: got %h want 00000000", rd); end
  endtask

  task automatic test_set_wins();
    // Falling switch toggles the debounced bit on the 6th edge; the clear lands on that same edge.
    sw_in = 10'h000;
    cyc(); cyc(); cyc(); cyc();
    bus.address = 14'h3; bus.byteena = 4'b1111; bus.data = 32'h004; bus.wren = 1'b1; bus.clken = 1'b1;
    cyc();
    bus.clken = 1'b0; bus.wren = 1'b0;
    cyc();
    bus_read(14'h3, rd);
    n_checks++;
    if (rd !== 32'h4) begin n_fail++; $display("FAIL set_wins: got %h want 00000004", rd); end
    bus_read(14'h2, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_fall: got %h want 00000000", rd); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_reassert: got %b want 1", irq); end
  endtask

  task automatic test_reset_mid_write();
    bus.address = 14'h0; bus.byteena = 4'b1111; bus.data = 32'h155; bus.wren = 1'b1; bus.clken = 1'b1;
    cyc();
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (led !== 10'h0 || hex !== 24'h0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: led=%h hex=%h irq=%b want 0 0 0", led, hex, irq);
    end
    bus.clken = 1'b0; bus.wren = 1'b0;
    cyc();
    #2 reset_n = 1'b1;
    cyc(); cyc();
    n_checks++;
    if (led !== 10'h0) begin n_fail++; $display("FAIL write_discarded: got %h want 000", led); end
    bus_read(14'h3, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL status_after_reset: got %h want 00000000", rd); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    sw_in    = '0;
    bus.address = '0; bus.byteena = '0; bus.data = '0; bus.wren = 1'b0; bus.clken = 1'b0;
    test_reset();
    test_led();
    test_hex();
    test_debounce();
    test_irq();
    test_set_wins();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
